// File: rtl/video_timing_pkg.sv
// Shared raster constants, pattern mode encoding and colour-bar table for the video timing generator.
package video_timing_pkg;

  localparam int H_ACTIVE_720 = 1280;
  localparam int H_FP_720     = 110;
  localparam int H_SYNC_720   = 40;
  localparam int H_BP_720     = 220;
  localparam int V_ACTIVE_720 = 720;
  localparam int V_FP_720     = 5;
  localparam int V_SYNC_720   = 5;
  localparam int V_BP_720     = 20;

  localparam int H_ACTIVE_480 = 640;
  localparam int H_FP_480     = 16;
  localparam int H_SYNC_480   = 96;
  localparam int H_BP_480     = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_GRADIENT = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_SOLID    = 2'd3
  } pat_e;

  // Returns {r,g,b} on/off flags for bar index 0..7, left to right.
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;  // white
      3'd1:    c = 3'b110;  // yellow
      3'd2:    c = 3'b011;  // cyan
      3'd3:    c = 3'b010;  // green
      3'd4:    c = 3'b101;  // magenta
      3'd5:    c = 3'b100;  // red
      3'd6:    c = 3'b001;  // blue
      default: c = 3'b000;  // black
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_rgb.sv
// Combinational test-pattern colour for pixel (h, v) in the selected mode; blanking is masked by the caller.
module video_pattern_rgb
  import video_timing_pkg::*;
#(
  parameter int CW       = 8,
  parameter int H_ACTIVE = 1280,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic [HW-1:0] h_i,
  input  logic [VW-1:0] v_i,
  input  pat_e          mode_i,
  output logic [CW-1:0] r_o,
  output logic [CW-1:0] g_o,
  output logic [CW-1:0] b_o
);

  localparam int BW = H_ACTIVE / 8;

  logic [31:0] h_ext;
  logic [31:0] v_ext;
  logic [31:0] bar_idx;
  logic [2:0]  bar_c;

  // Widen so the gradient and checker bit selects exist for any raster size.
  assign h_ext = 32'(h_i);
  assign v_ext = 32'(v_i);

  always_comb begin
    r_o     = '0;
    g_o     = '0;
    b_o     = '0;
    bar_c   = 3'b000;
    bar_idx = h_ext / BW;
    case (mode_i)
      PAT_BARS: begin
        if (bar_idx < 32'd8) bar_c = bar_colour(bar_idx[2:0]);
        r_o = {CW{bar_c[2]}};
        g_o = {CW{bar_c[1]}};
        b_o = {CW{bar_c[0]}};
      end
      PAT_GRADIENT: begin
        r_o = h_ext[CW-1:0];
        g_o = h_ext[CW-1:0];
        b_o = h_ext[CW-1:0];
      end
      PAT_CHECKER: begin
        if (h_ext[5] ^ v_ext[5]) begin
          r_o = '1;
          g_o = '1;
          b_o = '1;
        end
      end
      default: r_o = '1;
    endcase
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, h_ext, v_ext, bar_idx};

endmodule

// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator (hs/vs/de) with built-in pattern source; all outputs registered one pix_ce step after the counters.
module video_timing_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720,
  parameter int H_FP     = H_FP_720,
  parameter int H_SYNC   = H_SYNC_720,
  parameter int H_BP     = H_BP_720,
  parameter int V_ACTIVE = V_ACTIVE_720,
  parameter int V_FP     = V_FP_720,
  parameter int V_SYNC   = V_SYNC_720,
  parameter int V_BP     = V_BP_720,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = 8,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_100,
  input  logic          rst,
  input  logic          pix_ce,
  input  logic [1:0]    mode_sel,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          frame_start,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt
);

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0
      || H_ACTIVE < 8) begin : g_param_check
    $error("video_timing_pattern_gen: porch/sync widths must be nonzero and H_ACTIVE >= 8");
  end

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  pat_e          mode_q, mode_cur;
  logic          at_origin;
  logic          hs_d, vs_d, de_d;
  logic [CW-1:0] pat_r, pat_g, pat_b;
  logic [CW-1:0] r_d, g_d, b_d;

  logic          hs_q, vs_q, de_q, fs_q;
  logic [CW-1:0] r_q, g_q, b_q;
  logic [HW-1:0] hc_q;
  logic [VW-1:0] vc_q;

  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
  end

  // The request is taken at the frame origin and used for that very pixel,
  // so a new pattern starts exactly at (0,0) and never changes mid-frame.
  assign at_origin = (h_q == '0) && (v_q == '0);
  assign mode_cur  = at_origin ? pat_e'(mode_sel) : mode_q;

  assign hs_d = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
  assign vs_d = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
  assign de_d = (h_q < H_VIS) && (v_q < V_VIS);

  video_pattern_rgb #(
    .CW       (CW),
    .H_ACTIVE (H_ACTIVE),
    .HW       (HW),
    .VW       (VW)
  ) u_pattern (
    .h_i    (h_q),
    .v_i    (v_q),
    .mode_i (mode_cur),
    .r_o    (pat_r),
    .g_o    (pat_g),
    .b_o    (pat_b)
  );

  assign r_d = de_d ? pat_r : '0;
  assign g_d = de_d ? pat_g : '0;
  assign b_d = de_d ? pat_b : '0;

  always_ff @(posedge clk_100) begin
    if (rst) begin
      h_q    <= '0;
      v_q    <= '0;
      mode_q <= PAT_BARS;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      de_q   <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      fs_q   <= 1'b0;
      hc_q   <= '0;
      vc_q   <= '0;
    end else begin
      fs_q <= pix_ce & at_origin;
      if (pix_ce) begin
        h_q    <= h_d;
        v_q    <= v_d;
        mode_q <= mode_cur;
        hs_q   <= hs_d;
        vs_q   <= vs_d;
        de_q   <= de_d;
        r_q    <= r_d;
        g_q    <= g_d;
        b_q    <= b_d;
        hc_q   <= h_q;
        vc_q   <= v_q;
      end
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign frame_start = fs_q;
  assign h_cnt       = hc_q;
  assign v_cnt       = vc_q;

endmodule
